// File: rtl/imem_boot_controller_pkg.sv
// Shared definitions for the instruction-store boot controller and the core decoder.
package imem_boot_controller_pkg;

    localparam int DW            = 16;
    localparam int DEPTH_DEFAULT = 16;
    localparam logic [DW-1:0] NOP = 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } boot_state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, contents not reset.
module imem_ram
    import imem_boot_controller_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_boot_controller.sv
// Boot loader and access arbiter: clears the instruction RAM, streams a program in,
// then releases the core and serves fetches.
module imem_boot_controller
    import imem_boot_controller_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_start,
    input  logic          i_ld_valid,
    input  logic [DW-1:0] i_ld_data,
    input  logic          i_ld_last,
    output logic          o_ld_ready,
    input  logic [15:0]   i_fetch_pc,
    output logic [DW-1:0] o_fetch_instr,
    output logic          o_cpu_hold,
    output logic          o_busy,
    output logic [AW:0]   o_word_count,
    output logic          o_overflow
);

    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX    = AW'(DEPTH - 1);
    localparam logic [15:0]   FETCH_LIMIT = 16'(2 * DEPTH);

    boot_state_e r_state;
    boot_state_e w_state_nxt;

    logic [AW-1:0] r_clr_idx;
    logic [AW:0]   r_word_count;
    logic          r_overflow;

    logic          w_enter_clear;
    logic          w_xfer;
    logic          w_full;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata;
    logic          w_fetch_ok;

    assign w_full = (r_word_count == FULL_COUNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_clear = 1'b0;
        w_xfer        = 1'b0;
        w_we          = 1'b0;
        w_waddr       = r_clr_idx;
        w_wdata       = NOP;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_enter_clear = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_we = 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_xfer = i_ld_valid;
                if (i_ld_valid) begin
                    // words beyond capacity are accepted so the stream can drain
                    w_we    = !w_full;
                    w_waddr = r_word_count[AW-1:0];
                    w_wdata = i_ld_data;
                    if (i_ld_last) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_load_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_enter_clear = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_idx    <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_enter_clear) begin
            r_clr_idx    <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end else if (w_xfer) begin
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (i_fetch_pc[AW:1]),
        .o_rdata (w_rdata)
    );

    assign w_fetch_ok    = (r_state == ST_RUN) && (i_fetch_pc < FETCH_LIMIT);
    assign o_fetch_instr = w_fetch_ok ? w_rdata : NOP;
    assign o_ld_ready    = (r_state == ST_LOAD);
    assign o_cpu_hold    = (r_state != ST_RUN);
    assign o_busy        = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
    assign o_word_count  = r_word_count;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Self-checking bench for imem_boot_controller against a word-array reference model.
module tb_imem_boot_controller;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_start = 1'b0;
    logic        i_ld_valid = 1'b0;
    logic [15:0] i_ld_data = '0;
    logic        i_ld_last = 1'b0;
    logic        o_ld_ready;
    logic [15:0] i_fetch_pc = '0;
    logic [15:0] o_fetch_instr;
    logic        o_cpu_hold;
    logic        o_busy;
    logic [4:0]  o_word_count;
    logic        o_overflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_mem [16];
    int          m_count = 0;
    logic        m_ovf   = 1'b0;
    logic        m_run   = 1'b0;

    always #5 clk = ~clk;

    imem_boot_controller dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_ld_valid    (i_ld_valid),
        .i_ld_data     (i_ld_data),
        .i_ld_last     (i_ld_last),
        .o_ld_ready    (o_ld_ready),
        .i_fetch_pc    (i_fetch_pc),
        .o_fetch_instr (o_fetch_instr),
        .o_cpu_hold    (o_cpu_hold),
        .o_busy        (o_busy),
        .o_word_count  (o_word_count),
        .o_overflow    (o_overflow)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_fetch(input logic [15:0] pc);
        logic [3:0] idx;
        idx = pc[4:1];
        if (m_run && pc < 16'd32) return m_mem[idx];
        return 16'h0000;
    endfunction

    task automatic check_fetch(input logic [15:0] pc, input string tag);
        logic [15:0] exp;
        i_fetch_pc = pc;
        #1;
        exp = model_fetch(pc);
        n_total++;
        if (o_fetch_instr !== exp)
            $display("FAIL %s fetch pc=%0d: got %h expected %h", tag, pc, o_fetch_instr, exp);
        else n_pass++;
    endtask

    // Pulse load_start, then measure the clear phase until the loader is accepted.
    task automatic start_load(input string tag);
        int n;
        i_load_start = 1'b1;
        cycle();
        i_load_start = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_count = 0;
        m_ovf   = 1'b0;
        m_run   = 1'b0;
        n_total++;
        if (o_cpu_hold !== 1'b1 || o_busy !== 1'b1 || o_ld_ready !== 1'b0)
            $display("FAIL %s after start: hold=%b busy=%b ready=%b expected 1 1 0", tag, o_cpu_hold, o_busy, o_ld_ready);
        else n_pass++;
        n = 0;
        while (o_ld_ready !== 1'b1 && n < 64) begin
            cycle();
            n++;
        end
        n_total++;
        if (n !== 16)
            $display("FAIL %s clear length: got %0d cycles expected 16", tag, n);
        else n_pass++;
        n_total++;
        if (o_word_count !== 5'd0 || o_overflow !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL %s load entry: count=%0d ovf=%b busy=%b expected 0 0 1", tag, o_word_count, o_overflow, o_busy);
        else n_pass++;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input int max_gap, input string tag);
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        for (int g = 0; g < gap; g++) begin
            i_ld_valid = 1'b0;
            i_ld_data  = 16'($urandom);
            cycle();
            n_total++;
            if (o_ld_ready !== 1'b1 || o_word_count !== 5'(m_count))
                $display("FAIL %s idle gap: ready=%b count=%0d expected 1 %0d", tag, o_ld_ready, o_word_count, m_count);
            else n_pass++;
        end
        i_ld_valid = 1'b1;
        i_ld_data  = d;
        i_ld_last  = last;
        #1;
        n_total++;
        if (o_cpu_hold !== 1'b1 || o_ld_ready !== 1'b1)
            $display("FAIL %s before transfer: hold=%b ready=%b expected 1 1", tag, o_cpu_hold, o_ld_ready);
        else n_pass++;
        cycle();
        if (m_count < 16) begin
            m_mem[m_count] = d;
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        if (last) m_run = 1'b1;
        i_ld_valid = 1'b0;
        i_ld_last  = 1'b0;
        n_total++;
        if (o_word_count !== 5'(m_count) || o_overflow !== m_ovf || o_cpu_hold !== !m_run)
            $display("FAIL %s after transfer: count=%0d ovf=%b hold=%b expected %0d %b %b",
                     tag, o_word_count, o_overflow, o_cpu_hold, m_count, m_ovf, !m_run);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        cycle();
        cycle();
        i_reset = 1'b0;
        i_fetch_pc = 16'd0;
        #1;
        n_total++;
        if (o_fetch_instr !== 16'h0 || o_cpu_hold !== 1'b1 || o_ld_ready !== 1'b0 ||
            o_word_count !== 5'd0 || o_busy !== 1'b0 || o_overflow !== 1'b0)
            $display("FAIL reset state: instr=%h hold=%b ready=%b count=%0d busy=%b ovf=%b expected 0 1 0 0 0 0",
                     o_fetch_instr, o_cpu_hold, o_ld_ready, o_word_count, o_busy, o_overflow);
        else n_pass++;
        i_ld_valid = 1'b1;
        i_ld_last  = 1'b1;
        repeat (3) cycle();
        i_ld_valid = 1'b0;
        i_ld_last  = 1'b0;
        n_total++;
        if (o_ld_ready !== 1'b0 || o_word_count !== 5'd0 || o_cpu_hold !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL idle ignores loader: ready=%b count=%0d hold=%b busy=%b expected 0 0 1 0",
                     o_ld_ready, o_word_count, o_cpu_hold, o_busy);
        else n_pass++;
    endtask

    task automatic test_basic_load();
        logic [15:0] prog [6];
        prog = '{16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1, 16'hC07B};
        start_load("basic");
        for (int i = 0; i < 6; i++) send_word(prog[i], i == 5, 0, "basic");
        n_total++;
        if (o_cpu_hold !== 1'b0 || o_word_count !== 5'd6 || o_busy !== 1'b0 || o_ld_ready !== 1'b0)
            $display("FAIL basic run: hold=%b count=%0d busy=%b ready=%b expected 0 6 0 0",
                     o_cpu_hold, o_word_count, o_busy, o_ld_ready);
        else n_pass++;
        check_fetch(16'd2,  "basic");
        check_fetch(16'd10, "basic");
        check_fetch(16'd12, "basic");
        check_fetch(16'd32, "basic");
        check_fetch(16'd0,  "basic");
        check_fetch(16'd7,  "basic");
        check_fetch(16'hFFFE, "basic");
    endtask

    task automatic test_overflow();
        logic [15:0] w15;
        start_load("ovf");
        for (int i = 0; i < 17; i++) send_word(16'($urandom), i == 16, 0, "ovf");
        w15 = m_mem[15];
        i_fetch_pc = 16'd30;
        #1;
        n_total++;
        if (o_fetch_instr !== w15 || o_word_count !== 5'd16 || o_overflow !== 1'b1 || o_cpu_hold !== 1'b0)
            $display("FAIL overflow: instr=%h count=%0d ovf=%b hold=%b expected %h 16 1 0",
                     o_fetch_instr, o_word_count, o_overflow, o_cpu_hold, w15);
        else n_pass++;
        for (int a = 0; a < 34; a += 3) check_fetch(16'(a), "ovf");
    endtask

    task automatic test_reload();
        start_load("reload");
        send_word(16'h1234, 1'b0, 0, "reload");
        send_word(16'hBEEF, 1'b1, 0, "reload");
        check_fetch(16'd4, "reload");
        check_fetch(16'd0, "reload");
        check_fetch(16'd3, "reload");
        check_fetch(16'd30, "reload");
        n_total++;
        if (o_overflow !== 1'b0 || o_word_count !== 5'd2)
            $display("FAIL reload status: ovf=%b count=%0d expected 0 2", o_overflow, o_word_count);
        else n_pass++;
    endtask

    task automatic test_random_valid();
        int nwords;
        nwords = $urandom_range(5, 12);
        start_load("rand");
        for (int i = 0; i < nwords; i++) begin
            if (i == 2) begin
                i_load_start = 1'b1;
                cycle();
                i_load_start = 1'b0;
                n_total++;
                if (o_ld_ready !== 1'b1 || o_word_count !== 5'(m_count) || o_busy !== 1'b1)
                    $display("FAIL rand load_start ignored: ready=%b count=%0d busy=%b expected 1 %0d 1",
                             o_ld_ready, o_word_count, o_busy, m_count);
                else n_pass++;
            end
            send_word(16'($urandom), i == nwords - 1, 3, "rand");
        end
        for (int a = 0; a < 36; a++) check_fetch(16'(a), "rand");
    endtask

    task automatic test_reset_mid_load();
        start_load("midrst");
        for (int i = 0; i < 3; i++) send_word(16'($urandom) | 16'h0001, 1'b0, 1, "midrst");
        i_reset = 1'b1;
        cycle();
        i_reset = 1'b0;
        m_run   = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        n_total++;
        if (o_cpu_hold !== 1'b1 || o_busy !== 1'b0 || o_ld_ready !== 1'b0 || o_word_count !== 5'd0)
            $display("FAIL midrst idle: hold=%b busy=%b ready=%b count=%0d expected 1 0 0 0",
                     o_cpu_hold, o_busy, o_ld_ready, o_word_count);
        else n_pass++;
        for (int a = 0; a < 8; a++) check_fetch(16'(a), "midrst");
        start_load("midrst2");
        for (int i = 0; i < 4; i++) send_word(16'($urandom), i == 3, 2, "midrst2");
        for (int a = 0; a < 32; a += 2) check_fetch(16'(a), "midrst2");
        n_total++;
        if (o_overflow !== 1'b0 || o_word_count !== 5'd4)
            $display("FAIL midrst2 status: ovf=%b count=%0d expected 0 4", o_overflow, o_word_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_overflow();
        test_reload();
        test_random_valid();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
